// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   ADDR_W        byte address width of the PC / ROM address
//   INST_W        instruction word width
//   INST_BYTES    bytes per instruction (PC step)
//   fetch_entry_t {pc, inst} pair handed to decode
//   pc_next()     sequential PC, wrapping modulo 2^ADDR_W
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W     = 8;
  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Natural wrap of the ADDR_W-bit add gives the modulo behaviour (FC + 4 = 00).
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Fetch -> decode valid/ready handshake carrying one {pc, inst} pair.
//   if_valid  head entry valid (driven by fetch)
//   if_ready  decode accepts head when if_valid && if_ready
//   if_pc     PC of the head entry
//   if_inst   instruction of the head entry
// Modports: master = fetch side, slave = decode side.
// -----------------------------------------------------------------------------
interface fetch_if;
  import fetch_pkg::*;

  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;

  modport master (
    output if_valid,
    output if_pc,
    output if_inst,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_pc,
    input  if_inst,
    output if_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// Two-entry FIFO of fetch_entry_t with registered head outputs. Slot 0 is
// always the head, so the head value comes straight from a register.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push_i         write push_data_i at the edge (never asserted when full)
//   push_data_i    entry to write
//   pop_i          remove the head at the edge (ignored when empty)
//   flush_i        drop all entries; wins over push/pop
//   count_o        number of valid entries (0..2)
//   valid_o        head valid (count_o != 0)
//   head_o         head entry
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output logic         valid_o,
  output fetch_entry_t head_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_eff;

  assign pop_eff = pop_i && (count_q != 2'd0);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_i, pop_eff})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_data_i;
          else                 slot1_d = push_data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new entry lands
          // behind whatever survives the pop.
          if (count_q == 2'd1) begin
            slot0_d = push_data_i;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign head_o  = slot0_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage in front of a registered-output instruction ROM.
// Owns the PC, drives the ROM address every cycle, tracks which ROM responses
// are live, and buffers {pc, inst} pairs for decode in a 2-entry FIFO so
// backpressure never drops an instruction. Redirects flush all work.
// Ports:
//   clk, rst_n       clock shared with ROM, asynchronous active-low reset
//   rom_addr         ROM byte address (combinational copy of pc_q)
//   rom_inst         ROM data, valid the cycle after rom_addr
//   redirect_valid   take redirect_pc this cycle (highest priority)
//   redirect_pc      redirect target, low 2 bits ignored
//   dec              fetch_if.master handshake to decode
// Optional (macro FETCH_PERF_EN):
//   perf_fetched     saturating count of decode handshakes
//   perf_stall       saturating count of cycles if_valid && !if_ready
//   perf_flush       saturating count of redirects
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter int                BUF_DEPTH = 2
)
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_if.master           dec
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stall,
  output logic [7:0]        perf_flush
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_pend_q, req_pend_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;
  logic [1:0]        buf_count;
  logic              head_valid;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  assign pop = head_valid && dec.if_ready;

  // Entries the buffer will hold after this edge, counting the response
  // already in flight. A new request lands one edge later, so it may only
  // issue while that figure leaves room for it.
  always_comb begin
    occupancy = {1'b0, buf_count} + {2'b00, req_pend_q} - {2'b00, pop};
    issue     = !redirect_valid && (occupancy < 3'(BUF_DEPTH));
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    req_pend_d = 1'b0;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (issue) begin
      req_pend_d = 1'b1;
      req_pc_d   = pc_q;
      pc_d       = pc_next(pc_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      req_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      req_pend_q <= req_pend_d;
    end
  end

  assign rom_addr = pc_q;

  // A response arriving in a redirect cycle belongs to the squashed path.
  assign push       = req_pend_q && !redirect_valid;
  assign push_entry = '{pc: req_pc_q, inst: rom_inst};

  fetch_skid_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (buf_count),
    .valid_o     (head_valid),
    .head_o      (head)
  );

  assign dec.if_valid = head_valid;
  assign dec.if_pc    = head.pc;
  assign dec.if_inst  = head.inst;

`ifdef FETCH_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [15:0] perf_fetched_q;
  logic [15:0] perf_stall_q;
  logic [7:0]  perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 16'd0;
      perf_stall_q   <= 16'd0;
      perf_flush_q   <= 8'd0;
    end else begin
      if (pop)                         perf_fetched_q <= sat_inc16(perf_fetched_q);
      if (head_valid && !dec.if_ready) perf_stall_q   <= sat_inc16(perf_stall_q);
      if (redirect_valid)              perf_flush_q   <= sat_inc8(perf_flush_q);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        ready = 1'b1;
  logic [7:0]  rom_addr1, rom_addr2;
  logic [31:0] rom_q1, rom_q2;
  logic [31:0] rom_mem [64];
  logic [40:0] got;
  logic [40:0] want;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_if dif1 ();
  fetch_if dif2 ();
  assign dif1.if_ready = ready;
  assign dif2.if_ready = ready;

`ifdef FETCH_PERF_EN
  logic [15:0] pf_fetched1, pf_stall1, pf_fetched2, pf_stall2;
  logic [7:0]  pf_flush1, pf_flush2;
`endif

  fetch_unit #(.RESET_PC(8'h00), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr1), .rom_inst(rom_q1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec(dif1)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_fetched1), .perf_stall(pf_stall1), .perf_flush(pf_flush1)
`endif
  );

  fetch_unit #(.RESET_PC(8'hF8), .BUF_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr2), .rom_inst(rom_q2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec(dif2)
`ifdef FETCH_PERF_EN
    , .perf_fetched(pf_fetched2), .perf_stall(pf_stall2), .perf_flush(pf_flush2)
`endif
  );

  always #5 clk = ~clk;

  // Registered-output ROM model: data for rom_addr appears after the edge.
  always @(posedge clk) begin
    rom_q1 <= rom_mem[rom_addr1[7:2]];
    rom_q2 <= rom_mem[rom_addr2[7:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 0 (first issue cycle).
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    n_tests++;
    if (got !== 41'h0) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", got, 41'h0); end
    n_tests++;
    if (rom_addr1 !== 8'h00) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr1); end
    n_tests++;
    if (rom_addr2 !== 8'hF8) begin n_fail++; $display("FAIL reset_rom_addr_f8: got %h want f8", rom_addr2); end
`ifdef FETCH_PERF_EN
    n_tests++;
    if ({pf_fetched1, pf_stall1, pf_flush1} !== 40'h0) begin n_fail++; $display("FAIL reset_perf: got %h want 0", {pf_fetched1, pf_stall1, pf_flush1}); end
`endif
  endtask

  task automatic test_stream();
    logic [39:0] exp_tab [4];
    exp_tab = '{{8'h00, 32'h00450693}, {8'h04, 32'h00100713}, {8'h08, 32'h00b76463}, {8'h0C, 32'h00008067}};
    do_reset();
    for (int c = 0; c < 2; c++) begin
      n_tests++;
      if (dif1.if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency_c%0d: if_valid got %b want 0", c, dif1.if_valid); end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
      want = {1'b1, exp_tab[i]};
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL stream_entry%0d: got %h want %h", i, got, want); end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] exp_tab [4];
    exp_tab = '{{8'h04, 32'h00100713}, {8'h08, 32'h00b76463}, {8'h0C, 32'h00008067}, {8'h10, 32'hC0DE0010}};
    do_reset();
    step();
    step();
    step();
    ready = 1'b0;
    for (int c = 3; c <= 8; c++) begin
      got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
      want = {1'b1, 8'h04, 32'h00100713};
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL bp_hold_c%0d: got %h want %h", c, got, want); end
      if (c >= 4) begin
        n_tests++;
        if (rom_addr1 !== 8'h0C) begin n_fail++; $display("FAIL bp_issue_stop_c%0d: rom_addr got %h want 0c", c, rom_addr1); end
      end
      step();
    end
`ifdef FETCH_PERF_EN
    n_tests++;
    if (pf_stall1 !== 16'd6) begin n_fail++; $display("FAIL bp_perf_stall: got %0d want 6", pf_stall1); end
`endif
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
      want = {1'b1, exp_tab[i]};
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL bp_release%0d: got %h want %h", i, got, want); end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    step();
    step();
    step();
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    want = {1'b1, 8'h08, 32'h00b76463};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL redir_pre_head: got %h want %h", got, want); end
    redirect_valid = 1'b1;
    redirect_pc = 8'h1E;
    step();
    redirect_valid = 1'b0;
    n_tests++;
    if (dif1.if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush_c1: if_valid got %b want 0", dif1.if_valid); end
    n_tests++;
    if (rom_addr1 !== 8'h1C) begin n_fail++; $display("FAIL redir_target_addr: got %h want 1c", rom_addr1); end
`ifdef FETCH_PERF_EN
    n_tests++;
    if (pf_flush1 !== 8'd1) begin n_fail++; $display("FAIL redir_perf_flush: got %0d want 1", pf_flush1); end
    n_tests++;
    if (pf_fetched1 !== 16'd3) begin n_fail++; $display("FAIL redir_perf_fetched: got %0d want 3", pf_fetched1); end
`endif
    step();
    n_tests++;
    if (dif1.if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush_c2: if_valid got %b want 0", dif1.if_valid); end
    step();
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    want = {1'b1, 8'h1C, 32'hffc62883};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL redir_target: got %h want %h", got, want); end
    step();
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    want = {1'b1, 8'h20, 32'hC0DE0020};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL redir_follow: got %h want %h", got, want); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 8'h1E;
    step();
    redirect_pc = 8'h06;
    n_tests++;
    if (dif1.if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_flush_first: if_valid got %b want 0", dif1.if_valid); end
    step();
    redirect_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_tests++;
      if (dif1.if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_c%0d: if_valid got %b want 0", c, dif1.if_valid); end
      step();
    end
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    want = {1'b1, 8'h04, 32'h00100713};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL b2b_last_wins: got %h want %h", got, want); end
    step();
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    want = {1'b1, 8'h08, 32'h00b76463};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL b2b_follow: got %h want %h", got, want); end
  endtask

  task automatic test_wrap();
    logic [39:0] exp_tab [3];
    exp_tab = '{{8'hF8, 32'hC0DE00F8}, {8'hFC, 32'hC0DE00FC}, {8'h00, 32'h00450693}};
    do_reset();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      got = {dif2.if_valid, dif2.if_pc, dif2.if_inst};
      want = {1'b1, exp_tab[i]};
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL wrap_entry%0d: got %h want %h", i, got, want); end
      step();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    n_tests++;
    if (got !== 41'h0) begin n_fail++; $display("FAIL async_rst_outputs: got %h want %h", got, 41'h0); end
    n_tests++;
    if (rom_addr1 !== 8'h00) begin n_fail++; $display("FAIL async_rst_rom_addr: got %h want 00", rom_addr1); end
    #1;
    rst_n = 1'b1;
    step();
    n_tests++;
    if (dif1.if_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_latency: if_valid got %b want 0", dif1.if_valid); end
    step();
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    want = {1'b1, 8'h00, 32'h00450693};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL async_rst_restart: got %h want %h", got, want); end
    step();
    got = {dif1.if_valid, dif1.if_pc, dif1.if_inst};
    want = {1'b1, 8'h04, 32'h00100713};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL async_rst_follow: got %h want %h", got, want); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = {16'hC0DE, 8'h00, 6'(i), 2'b00};
    rom_mem[0]  = 32'h00450693;
    rom_mem[1]  = 32'h00100713;
    rom_mem[2]  = 32'h00b76463;
    rom_mem[3]  = 32'h00008067;
    rom_mem[7]  = 32'hffc62883;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
